hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS datapath. It consumes the register specifiers and write-back controls the datapath exports from stages D/E/M/W and drives the stall, flush and forward selects back into that datapath. Beyond the combinational hazard equations, it holds three pieces of state:
- a memory-wait FSM that freezes the whole pipeline while a multi-cycle data memory is busy;
- a wait-timeout counter;
- saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive WAIT cycles before the access is abandoned
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rsD  in  5  rs specifier, decode stage
rtD  in  5  rt specifier, decode stage
rsE  in  5  rs specifier, execute stage
rtE  in  5  rt specifier, execute stage
writeregE  in  5  destination register, execute stage
writeregM  in  5  destination register, memory stage
writeregW  in  5  destination register, writeback stage
regwriteE  in  1  register write enable, execute stage
regwriteM  in  1  register write enable, memory stage
regwriteW  in  1  register write enable, writeback stage
memtoregE  in  1  load in execute stage
memtoregM  in  1  load in memory stage
branchD  in  1  branch in decode stage
memaccessM  in  1  load or store in memory stage
mem_ready  in  1  data memory completes access this cycle
perf_clr  in  1  synchronous clear of the performance counters
stallF  out  1  hold PC
stallD  out  1  hold the IF/ID register
stallE  out  1  hold the ID/EX register
stallM  out  1  hold the EX/MEM register
stallW  out  1  hold the MEM/WB register
flushE  out  1  clear the ID/EX register
forwardAD  out  1  branch comparator A takes aluoutM
forwardBD  out  1  branch comparator B takes aluoutM
forwardAE  out  2  ALU source A select (00 = regfile, 01 = resultW, 10 = aluoutM)
forwardBE  out  2  ALU source B select (00 = regfile, 01 = resultW, 10 = aluoutM)
mem_req  out  1  access request to the data memory
mem_err  out  1  sticky timeout flag
hazard_stall_cnt  out  CNT_W  cycles stalled on data hazards
mem_wait_cnt  out  CNT_W  cycles frozen on memory
flush_cnt  out  CNT_W  number of E-stage flushes

Behaviour:
- Forwarding (combinational):
  - forwardAE = 10 if rsE!=0 && rsE==writeregM && regwriteM; else 01 if rsE!=0 && rsE==writeregW && regwriteW; else 00. The M-stage match has priority.
  - forwardBE uses the same rule with rtE.
  - forwardAD = rsD!=0 && rsD==writeregM && regwriteM.
  - forwardBD uses the same rule with rtD.
- Hazard terms:
  - lwstall = memtoregE && (rtE==rsD || rtE==rtD).
  - branchstall = branchD && ((regwriteE && writeregE∈{rsD,rtD}) || (memtoregM && writeregM∈{rsD,rtD})).
  - hstall = lwstall | branchstall.
- Memory FSM, states RUN and WAIT:
  - mem_req = memaccessM && state∈{RUN, WAIT}.
  - RUN: freeze = memaccessM && !mem_ready. If freeze, go to WAIT and set wait_ctr=1.
  - WAIT: freeze = !mem_ready.
    - If mem_ready, go to RUN.
    - Else if wait_ctr==MEM_TIMEOUT, set mem_err=1, freeze=0 this cycle, go to RUN.
    - Else increment wait_ctr.
  - mem_err is sticky; it clears only on reset.
- Stall and flush outputs:
  - stallF = stallD = hstall | freeze.
  - stallE = stallM = stallW = freeze.
  - flushE = hstall && !freeze. A freeze suppresses the flush so the frozen E-stage contents are not lost.
- Counters:
  - hazard_stall_cnt increments when hstall && !freeze.
  - mem_wait_cnt increments when freeze.
  - flush_cnt increments when flushE.
  - All three saturate at 2^CNT_W-1.
  - perf_clr zeroes all three on the next edge and has priority over increments in that cycle.
- Reset:
  - state=RUN, wait_ctr=0, mem_err=0, all counters 0.
  - While reset is asserted all stall, flush and forward outputs are 0 and mem_req=0.
  - Reset asserted during WAIT returns to RUN on the next edge.
- Simultaneous events:
  - mem_ready on the first access cycle produces no freeze and no state change.
  - hstall together with freeze: the stalls from both apply, flushE=0, and only mem_wait_cnt increments.

Decomposition:
- Package hazard_pkg: forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; FSM state encoding RUN/WAIT.
- Sub-module hazard_mem_fsm: contains the state register, wait_ctr, mem_err and the freeze/mem_req logic.
- Top level: forwarding and hazard equations, performance counters.

Test Plan:
- rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardAE=10. Drop regwriteM -> forwardAE=01. Set rsE=0 -> forwardAE=00.
- memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1, stallE=0. Next cycle memtoregE=0 -> all 0. hazard_stall_cnt=1, flush_cnt=1.
- branchD=1, rsD=7, writeregE=7, regwriteE=1 -> stallD=1, flushE=1. Then writeregM=7, regwriteM=1, memtoregM=0, regwriteE=0 -> no stall, forwardAD=1.
- memaccessM=1, mem_ready low 3 cycles then high -> freeze for 3 cycles (stallF..stallW=1), mem_req=1 throughout, mem_wait_cnt=3, returns to RUN.
- MEM_TIMEOUT=4, mem_ready held low -> mem_err=1 at the 5th frozen-cycle decision, freeze released, mem_err stays 1 until reset.
- Load-use during a memory wait -> flushE=0, stallE=1. Assert perf_clr together with an increment -> all counters read 0 next cycle. Reset in WAIT -> RUN next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - forward-select encodings driven onto the ALU source muxes
//   - memory-wait FSM state encoding
//   - fwdSelect(): priority forward-select helper used for both ALU operands
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;   // operand from the register file
   localparam logic [1:0] FWD_WB  = 2'b01;   // operand from resultW
   localparam logic [1:0] FWD_MEM = 2'b10;   // operand from aluoutM

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } memState_t;

   // The M-stage producer is younger than the W-stage one, so it wins.
   // Register 0 is hard-wired and is never forwarded.
   function automatic logic [1:0] fwdSelect(input logic [4:0] src,
                                            input logic [4:0] wrM,
                                            input logic       wenM,
                                            input logic [4:0] wrW,
                                            input logic       wenW);
      if (src != 5'd0 && src == wrM && wenM)
         return FWD_MEM;
      else if (src != 5'd0 && src == wrW && wenW)
         return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// hazard_mem_fsm
// Freezes the pipeline while a multi-cycle data memory access is pending and
// abandons the access after MEM_TIMEOUT consecutive wait cycles.
//
// state | meaning
// ------+----------------------------------------------------------------
// RUN   | no access outstanding; a not-ready access freezes and enters WAIT
// WAIT  | access outstanding; waitCtr counts frozen cycles spent here
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   memaccessM    load/store in the memory stage
//   mem_ready     memory completes the access this cycle
//   freeze        combinational: hold every pipeline register this cycle
//   mem_req       combinational: access request to the data memory
//   mem_err       registered, sticky timeout flag (cleared only by reset)
module hazard_mem_fsm
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic memaccessM,
   input  logic mem_ready,
   output logic freeze,
   output logic mem_req,
   output logic mem_err
);

   localparam int CTR_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CTR_W-1:0] TIMEOUT_VAL = CTR_W'(MEM_TIMEOUT);

   memState_t        state;
   logic [CTR_W-1:0] waitCtr;
   logic             timeoutHit;

   always_comb begin
      timeoutHit = (state == WAIT) && !mem_ready && (waitCtr == TIMEOUT_VAL);
      freeze     = 1'b0;
      unique case (state)
         RUN:  freeze = memaccessM && !mem_ready;
         WAIT: freeze = !mem_ready && !timeoutHit;   // timeout releases the pipe
         default: freeze = 1'b0;
      endcase
      if (reset)
         freeze = 1'b0;
      // Both states request while an access is present.
      mem_req = memaccessM && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RUN;
         waitCtr <= '0;
         mem_err <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (memaccessM && !mem_ready) begin
                  state   <= WAIT;
                  waitCtr <= CTR_W'(1);
               end
            end
            WAIT: begin
               if (mem_ready) begin
                  state   <= RUN;
                  waitCtr <= '0;
               end else if (waitCtr == TIMEOUT_VAL) begin
                  mem_err <= 1'b1;
                  state   <= RUN;
                  waitCtr <= '0;
               end else begin
                  waitCtr <= waitCtr + CTR_W'(1);
               end
            end
            default: begin
               state   <= RUN;
               waitCtr <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use / branch stall detection, memory-wait freeze and saturating
// performance counters.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rsD/rtD, rsE/rtE                source register specifiers (D, E stages)
//   writeregE/M/W, regwriteE/M/W    destination register and write enables
//   memtoregE/M                     load in E / M stage
//   branchD                         branch in decode
//   memaccessM, mem_ready           data-memory handshake
//   perf_clr                        synchronous clear of the counters
//   stallF..stallW, flushE          pipeline register controls
//   forwardAD/BD, forwardAE/BE      forward selects
//   mem_req, mem_err                memory request, sticky timeout flag
//   hazard_stall_cnt, mem_wait_cnt,
//   flush_cnt                       saturating performance counters
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rsD,
   input  logic [4:0]       rtD,
   input  logic [4:0]       rsE,
   input  logic [4:0]       rtE,
   input  logic [4:0]       writeregE,
   input  logic [4:0]       writeregM,
   input  logic [4:0]       writeregW,
   input  logic             regwriteE,
   input  logic             regwriteM,
   input  logic             regwriteW,
   input  logic             memtoregE,
   input  logic             memtoregM,
   input  logic             branchD,
   input  logic             memaccessM,
   input  logic             mem_ready,
   input  logic             perf_clr,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             stallW,
   output logic             flushE,
   output logic             forwardAD,
   output logic             forwardBD,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             mem_req,
   output logic             mem_err,
   output logic [CNT_W-1:0] hazard_stall_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic freeze;
   logic lwStall;
   logic branchStall;
   logic hstall;

   hazard_mem_fsm #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_memFsm (
      .clk       (clk),
      .reset     (reset),
      .memaccessM(memaccessM),
      .mem_ready (mem_ready),
      .freeze    (freeze),
      .mem_req   (mem_req),
      .mem_err   (mem_err)
   );

   always_comb begin
      lwStall     = memtoregE && (rtE == rsD || rtE == rtD);
      // Branch compares in D: an ALU result still in E, or a load still in M,
      // cannot be forwarded in time.
      branchStall = branchD &&
                    ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                     (memtoregM && (writeregM == rsD || writeregM == rtD)));
      hstall      = !reset && (lwStall || branchStall);

      forwardAE = reset ? FWD_RF : fwdSelect(rsE, writeregM, regwriteM, writeregW, regwriteW);
      forwardBE = reset ? FWD_RF : fwdSelect(rtE, writeregM, regwriteM, writeregW, regwriteW);
      forwardAD = !reset && rsD != 5'd0 && rsD == writeregM && regwriteM;
      forwardBD = !reset && rtD != 5'd0 && rtD == writeregM && regwriteM;

      stallF = hstall || freeze;
      stallD = hstall || freeze;
      stallE = freeze;
      stallM = freeze;
      stallW = freeze;
      // A frozen E stage must keep its contents, so the bubble is withheld.
      flushE = hstall && !freeze;
   end

   always_ff @(posedge clk) begin
      if (reset || perf_clr) begin
         hazard_stall_cnt <= '0;
         mem_wait_cnt     <= '0;
         flush_cnt        <= '0;
      end else begin
         if (hstall && !freeze && hazard_stall_cnt != CNT_MAX)
            hazard_stall_cnt <= hazard_stall_cnt + CNT_W'(1);
         if (freeze && mem_wait_cnt != CNT_MAX)
            mem_wait_cnt <= mem_wait_cnt + CNT_W'(1);
         if (flushE && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Scoreboard bench for hazard_ctrl. Each cycle the driver applies inputs,
// a behavioural model predicts the outputs and pushes them to a queue, and
// the entry is popped and compared against the DUT mid-cycle.
module tb_hazard_ctrl;

   localparam int TO  = 4;
   localparam int CW  = 4;
   localparam int MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
   logic          branchD, memaccessM, mem_ready, perf_clr;
   logic          stallF, stallD, stallE, stallM, stallW, flushE;
   logic          forwardAD, forwardBD;
   logic [1:0]    forwardAE, forwardBE;
   logic          mem_req, mem_err;
   logic [CW-1:0] hazard_stall_cnt, mem_wait_cnt, flush_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
      .memaccessM(memaccessM), .mem_ready(mem_ready), .perf_clr(perf_clr),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .stallW(stallW), .flushE(flushE), .forwardAD(forwardAD),
      .forwardBD(forwardBD), .forwardAE(forwardAE), .forwardBE(forwardBE),
      .mem_req(mem_req), .mem_err(mem_err),
      .hazard_stall_cnt(hazard_stall_cnt), .mem_wait_cnt(mem_wait_cnt),
      .flush_cnt(flush_cnt)
   );

   typedef struct {
      string      name;
      logic [4:0] stalls;     // {F,D,E,M,W}
      logic       flush;
      logic [1:0] fwdD;       // {AD,BD}
      logic [1:0] fwdAE;
      logic [1:0] fwdBE;
      logic       memReq;
      logic       memErr;
      int         hs;
      int         mw;
      int         fl;
   } expect_t;

   expect_t sb[$];
   int      nTests = 0;
   int      nFail  = 0;

   // model state
   bit mWait = 0;
   int mCtr  = 0;
   bit mErr  = 0;
   int mHs = 0, mMw = 0, mFl = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] fwdModel(input logic [4:0] src);
      if (reset) return 2'b00;
      if (src != 0 && src == writeregM && regwriteM) return 2'b10;
      if (src != 0 && src == writeregW && regwriteW) return 2'b01;
      return 2'b00;
   endfunction

   task automatic idle();
      rsD = 0; rtD = 0; rsE = 0; rtE = 0;
      writeregE = 0; writeregM = 0; writeregW = 0;
      regwriteE = 0; regwriteM = 0; regwriteW = 0;
      memtoregE = 0; memtoregM = 0; branchD = 0;
      memaccessM = 0; mem_ready = 0; perf_clr = 0;
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic step(input string name);
      expect_t e, o;
      logic lw, br, hs, fr;
      lw = memtoregE && (rtE == rsD || rtE == rtD);
      br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                       (memtoregM && (writeregM == rsD || writeregM == rtD)));
      hs = !reset && (lw || br);
      if (reset)       fr = 0;
      else if (!mWait) fr = memaccessM && !mem_ready;
      else             fr = !mem_ready && (mCtr != TO);

      e.name   = name;
      e.stalls = {hs | fr, hs | fr, fr, fr, fr};
      e.flush  = hs && !fr;
      e.fwdD   = {!reset && rsD != 0 && rsD == writeregM && regwriteM,
                  !reset && rtD != 0 && rtD == writeregM && regwriteM};
      e.fwdAE  = fwdModel(rsE);
      e.fwdBE  = fwdModel(rtE);
      e.memReq = memaccessM && !reset;
      e.memErr = mErr;
      e.hs = mHs; e.mw = mMw; e.fl = mFl;
      sb.push_back(e);

      #2;
      o = sb.pop_front();
      checkVal({o.name, ".stalls"}, 32'({stallF, stallD, stallE, stallM, stallW}), 32'(o.stalls));
      checkVal({o.name, ".flushE"}, 32'(flushE), 32'(o.flush));
      checkVal({o.name, ".fwdD"}, 32'({forwardAD, forwardBD}), 32'(o.fwdD));
      checkVal({o.name, ".fwdAE"}, 32'(forwardAE), 32'(o.fwdAE));
      checkVal({o.name, ".fwdBE"}, 32'(forwardBE), 32'(o.fwdBE));
      checkVal({o.name, ".mem_req"}, 32'(mem_req), 32'(o.memReq));
      checkVal({o.name, ".mem_err"}, 32'(mem_err), 32'(o.memErr));
      checkVal({o.name, ".hs_cnt"}, 32'(hazard_stall_cnt), o.hs);
      checkVal({o.name, ".mw_cnt"}, 32'(mem_wait_cnt), o.mw);
      checkVal({o.name, ".fl_cnt"}, 32'(flush_cnt), o.fl);

      @(posedge clk);
      if (reset) begin
         mWait = 0; mCtr = 0; mErr = 0; mHs = 0; mMw = 0; mFl = 0;
      end else begin
         if (!mWait) begin
            if (memaccessM && !mem_ready) begin mWait = 1; mCtr = 1; end
         end else if (mem_ready) begin
            mWait = 0; mCtr = 0;
         end else if (mCtr == TO) begin
            mErr = 1; mWait = 0; mCtr = 0;
         end else begin
            mCtr++;
         end
         if (perf_clr) begin
            mHs = 0; mMw = 0; mFl = 0;
         end else begin
            if (hs && !fr && mHs < MAX) mHs++;
            if (fr && mMw < MAX) mMw++;
            if (hs && !fr && mFl < MAX) mFl++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1;
      @(posedge clk);
      @(negedge clk);

      // reset masks every combinational output
      rsE = 3; writeregM = 3; regwriteM = 1; memaccessM = 1;
      memtoregE = 1; rtE = 5; rsD = 5;
      step("rst0");
      step("rst1");
      reset = 0;

      // forwarding priority
      idle(); rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
      rtE = 4;
      step("fwdMem");
      regwriteM = 0;
      step("fwdWb");
      rsE = 0;
      step("fwdR0");
      idle(); rtE = 6; writeregW = 6; regwriteW = 1; rsE = 9; writeregM = 9; regwriteM = 1;
      step("fwdMix");

      // load-use
      idle(); memtoregE = 1; rtE = 5; rsD = 5;
      step("ldUse");
      memtoregE = 0;
      step("ldUseDone");

      // branch hazards
      idle(); branchD = 1; rsD = 7; writeregE = 7; regwriteE = 1;
      step("brE");
      regwriteE = 0; writeregM = 7; regwriteM = 1;
      step("brFwd");
      idle(); branchD = 1; rtD = 9; writeregM = 9; memtoregM = 1; regwriteM = 1;
      step("brLoadM");

      // three-cycle memory wait
      idle(); memaccessM = 1;
      for (int i = 0; i < 3; i++) step($sformatf("memWait%0d", i));
      mem_ready = 1;
      step("memDone");
      step("memFirstReady");
      idle();
      step("memIdle");

      // load-use while frozen
      memaccessM = 1; memtoregE = 1; rtE = 5; rsD = 5;
      step("ldUseFrz0");
      step("ldUseFrz1");
      mem_ready = 1;
      step("ldUseFrzEnd");

      // counter saturation
      idle(); memtoregE = 1; rtE = 2; rtD = 2;
      for (int i = 0; i < 18; i++) step($sformatf("sat%0d", i));

      // clear wins over an increment
      perf_clr = 1;
      step("clr");
      idle();
      step("clrDone");

      // timeout
      memaccessM = 1;
      for (int i = 0; i < 5; i++) step($sformatf("tmo%0d", i));
      idle();
      step("errSticky0");
      step("errSticky1");

      // reset while waiting
      memaccessM = 1;
      step("rstWait0");
      step("rstWait1");
      reset = 1;
      step("rstInWait");
      reset = 0;
      for (int i = 0; i < 6; i++) step($sformatf("postRst%0d", i));
      idle();
      step("final");

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
